// File: rtl/aq_axis_pkt_gen_pkg.sv
// aq_axis_pkt_gen_pkg
//   Shared definitions for the AXI4-Stream packet generator.
//   - state_e      : FSM state encoding
//   - HDR_LEN_LSB  : bit offset of the packet length field in the header beat
//   - hdr_seq_lsb(): bit offset of the sequence field (sits just above the length field)
package aq_axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int HDR_LEN_LSB = 0;

    // The sequence field starts right above the length field, whose width is a
    // parameter of the generator, so the offset is derived from it.
    function automatic int hdr_seq_lsb(input int len_width);
        return len_width;
    endfunction

endpackage

// File: rtl/aq_axis_pkt_payload.sv
// aq_axis_pkt_payload
//   Payload data register and beat counter for the packet generator.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     load       : load data with seed and clear the beat counter (run start)
//     adv        : a payload beat transferred this cycle
//     seed       : first payload value of the run
//     pkt_len    : latched payload beats per packet (0 behaves as 1)
//     data       : current payload value
//     last       : current payload beat is the final one of the packet
module aq_axis_pkt_payload #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  len_eff;

    always_comb begin
        len_eff = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
        last    = (beat_q == len_eff - LEN_WIDTH'(1));
        data_d  = data_q;
        beat_d  = beat_q;
        if (load) begin
            data_d = seed;
            beat_d = '0;
        end else if (adv) begin
            // Data keeps counting across packet boundaries; only the beat index wraps.
            data_d = data_q + DATA_WIDTH'(1);
            beat_d = last ? '0 : beat_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            beat_q <= '0;
        end else begin
            data_q <= data_d;
            beat_q <= beat_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/aq_axis_pkt_gen.sv
// aq_axis_pkt_gen
//   AXI4-Stream packet source for driving the write side of an AXIS FIFO.
//   Emits runs of fixed-length packets with an incrementing data pattern,
//   optional inter-packet gaps and packet-boundary throttling.
//   Ports:
//     M_AXIS_ACLK, RST_N        : clock, synchronous active-low reset
//     START / STOP              : run start pulse / end-at-packet-boundary pulse
//     PKT_LEN/PKT_NUM/PKT_GAP/SEED : run configuration, latched at START
//     THROTTLE                  : holds off the next packet start (FIFO almost-full)
//     M_AXIS_TVALID/TREADY/TLAST/TDATA : AXI4-Stream master
//     BUSY, DONE, PKT_COUNT     : status
//   Build option: define AQ_AXIS_PKT_GEN_HDR_EN to prepend a header beat
//   {zeros, seq[15:0], PKT_LEN} to every packet.
module aq_axis_pkt_gen
    import aq_axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [LEN_WIDTH-1:0]  PKT_LEN,
    input  logic [15:0]           PKT_NUM,
    input  logic [GAP_WIDTH-1:0]  PKT_GAP,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic                  THROTTLE,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           PKT_COUNT
);

    state_e                 state_q, state_d;
    logic                   stop_q, stop_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [15:0]            num_q, num_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]            pkt_cnt_q, pkt_cnt_d;
    logic                   tvalid_q, tvalid_d;
    logic                   done_q, done_d;

    logic                   xfer, pay_xfer, pkt_end, stop_pend, pay_load, pay_last;
    logic [15:0]            pkt_cnt_inc;
    logic [DATA_WIDTH-1:0]  pay_data;
    state_e                 arm_ns;

`ifdef AQ_AXIS_PKT_GEN_HDR_EN
    localparam int HDR_SEQ_LSB = hdr_seq_lsb(LEN_WIDTH);
    logic                  hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] hdr_word;
`endif

    aq_axis_pkt_payload #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_payload (
        .clk     (M_AXIS_ACLK),
        .rst_n   (RST_N),
        .load    (pay_load),
        .adv     (pay_xfer),
        .seed    (SEED),
        .pkt_len (len_q),
        .data    (pay_data),
        .last    (pay_last)
    );

    always_comb begin
        xfer        = tvalid_q & M_AXIS_TREADY;
`ifdef AQ_AXIS_PKT_GEN_HDR_EN
        pay_xfer    = xfer & ~hdr_q;
`else
        pay_xfer    = xfer;
`endif
        pkt_end     = pay_xfer & pay_last;
        pkt_cnt_inc = pkt_cnt_q + 16'd1;
        stop_pend   = stop_q | STOP;
        pay_load    = (state_q == ST_IDLE) & START;
        // Decision taken whenever the FSM is ready to begin a new packet.
        arm_ns      = stop_pend ? ST_IDLE : (THROTTLE ? ST_ARM : ST_SEND);

        state_d   = state_q;
        stop_d    = stop_pend;
        len_d     = len_q;
        num_d     = num_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A STOP alone in IDLE is dropped; together with START it ends the run in ARM.
                stop_d = START & STOP;
                if (START) begin
                    len_d     = PKT_LEN;
                    num_d     = PKT_NUM;
                    gap_d     = PKT_GAP;
                    pkt_cnt_d = '0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: state_d = arm_ns;
            ST_GAP: begin
                // The last gap cycle already makes the ARM decision so the idle
                // stretch between packets is exactly PKT_GAP cycles.
                if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = arm_ns;
                else                            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            end
            ST_SEND: begin
                if (pkt_end) begin
                    pkt_cnt_d = pkt_cnt_inc;
                    if (((num_q != '0) && (pkt_cnt_inc == num_q)) || stop_pend) begin
                        state_d = ST_IDLE;
                    end else if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end else if (!THROTTLE) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_d = 1'b0;
        tvalid_d = (state_d == ST_SEND);
        done_d   = (state_q != ST_IDLE) && (state_d == ST_IDLE);

`ifdef AQ_AXIS_PKT_GEN_HDR_EN
        // Header is owed on every entry into SEND and on a zero-bubble packet restart.
        hdr_d = hdr_q;
        if ((state_d == ST_SEND) && ((state_q != ST_SEND) || pkt_end)) hdr_d = 1'b1;
        else if (xfer)                                                 hdr_d = 1'b0;
        hdr_word = '0;
        hdr_word[HDR_LEN_LSB +: LEN_WIDTH] = len_q;
        hdr_word[HDR_SEQ_LSB +: 16]        = pkt_cnt_q;
`endif
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            stop_q    <= 1'b0;
            len_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            pkt_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef AQ_AXIS_PKT_GEN_HDR_EN
            hdr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            len_q     <= len_d;
            num_q     <= num_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            tvalid_q  <= tvalid_d;
            done_q    <= done_d;
`ifdef AQ_AXIS_PKT_GEN_HDR_EN
            hdr_q     <= hdr_d;
`endif
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
`ifdef AQ_AXIS_PKT_GEN_HDR_EN
    assign M_AXIS_TLAST  = tvalid_q & pay_last & ~hdr_q;
    assign M_AXIS_TDATA  = hdr_q ? hdr_word : pay_data;
`else
    assign M_AXIS_TLAST  = tvalid_q & pay_last;
    assign M_AXIS_TDATA  = pay_data;
`endif
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign PKT_COUNT = pkt_cnt_q;

endmodule
